// File: rtl/overflow_clock_divider.sv
// Overflow-counter clock divider: a WIDTH-bit phase accumulator advances by STEP
// per enabled clk edge, and each carry out of the top bit toggles dividedClk.
module overflow_clock_divider #(
    parameter int unsigned WIDTH = 27,
    parameter int unsigned STEP  = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic dividedClk
);

    if (WIDTH < 1 || WIDTH > 32) begin : gBadWidth
        $error("overflow_clock_divider: WIDTH must be in 1..32");
    end

    if (STEP < 1 || 64'(STEP) >= (64'd1 << WIDTH)) begin : gBadStep
        $error("overflow_clock_divider: STEP must satisfy 1 <= STEP < 2**WIDTH");
    end

    localparam logic [WIDTH:0] STEP_EXT = (WIDTH + 1)'(STEP);

    logic [WIDTH-1:0] acc;
    logic [WIDTH:0]   sum;

    // The extra top bit of the sum is the carry; the low bits keep the remainder.
    assign sum = {1'b0, acc} + STEP_EXT;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc        <= '0;
            dividedClk <= 1'b0;
        end else if (enable) begin
            acc <= sum[WIDTH-1:0];
            if (sum[WIDTH]) begin
                dividedClk <= ~dividedClk;
            end
        end
    end

endmodule

// File: tb/tb_overflow_clock_divider.sv
// Scoreboarded bench for overflow_clock_divider: three instances (W4/S1, W4/S3, W1/S1)
// compared every cycle against an arithmetic model based on the count of enabled edges.
module tb_overflow_clock_divider;

    logic clk;
    logic reset;
    logic enable;
    logic dClk0;
    logic dClk1;
    logic dClk2;

    overflow_clock_divider #(.WIDTH(4), .STEP(1)) dut0 (
        .clk(clk), .reset(reset), .enable(enable), .dividedClk(dClk0)
    );
    overflow_clock_divider #(.WIDTH(4), .STEP(3)) dut1 (
        .clk(clk), .reset(reset), .enable(enable), .dividedClk(dClk1)
    );
    overflow_clock_divider #(.WIDTH(1), .STEP(1)) dut2 (
        .clk(clk), .reset(reset), .enable(enable), .dividedClk(dClk2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    longint unsigned nEdges;
    logic [2:0]      expQ[$];
    int              vectors;
    int              errors;
    int              toggles1;
    logic            prev1;

    // Output level = parity of the number of carries so far = floor(n*STEP / 2^W) mod 2.
    function automatic logic [2:0] model();
        logic [2:0] r;
        r[0] = ((nEdges * 1) >> 4) % 2 == 1;
        r[1] = ((nEdges * 3) >> 4) % 2 == 1;
        r[2] = ((nEdges * 1) >> 1) % 2 == 1;
        return r;
    endfunction

    function automatic logic expHigh0();
        logic [2:0] r;
        r = model();
        return r[0];
    endfunction

    task automatic step(input logic en);
        enable = en;
        @(posedge clk);
        if (reset && en) nEdges++;
        expQ.push_back(model());
        #1;
    endtask

    // One counting edge, then reset asserted 3 ns later, inside the same cycle.
    task automatic stepReset(input logic en);
        enable = en;
        @(posedge clk);
        if (reset && en) nEdges++;
        #3;
        reset  = 1'b0;
        nEdges = 0;
        expQ.push_back(model());
        #1;
    endtask

    initial begin
        toggles1 = 0;
        prev1    = 1'b0;
    end

    always @(negedge clk) begin
        logic [2:0] exp;
        logic [2:0] got;
        got = {dClk2, dClk1, dClk0};
        if (expQ.size() > 0) begin
            exp = expQ.pop_front();
            vectors++;
            if (got !== exp) begin
                errors++;
                $display("FAIL dividedClk {w1s1,w4s3,w4s1}: got %b expected %b at %0t", got, exp, $time);
            end
        end
        if (prev1 !== dClk1) toggles1++;
        prev1 = dClk1;
    end

    initial begin
        int t0;
        int n;
        vectors = 0;
        errors  = 0;
        nEdges  = 0;
        reset   = 1'b0;
        enable  = 1'b0;

        // Reset with enable low, release near 23 ns, then 60 ns of idle.
        repeat (2) step(1'b0);
        #7;
        reset = 1'b1;
        repeat (6) step(1'b0);

        // Many full periods with enable held high.
        repeat (16 * 18) step(1'b1);

        // Enable gap of 5 cycles at acc == 10.
        while (nEdges % 16 != 10) step(1'b1);
        repeat (5) step(1'b0);
        repeat (40) step(1'b1);

        // Asynchronous reset while dividedClk is high.
        while (!expHigh0()) step(1'b1);
        step(1'b1);
        stepReset(1'b1);
        repeat (3) step(1'b1);
        reset = 1'b1;
        repeat (40) step(1'b1);

        // STEP = 3: 480 enabled edges from reset yield 90 toggles.
        stepReset(1'b1);
        step(1'b1);
        reset = 1'b1;
        t0 = toggles1;
        repeat (480) step(1'b1);
        #6;
        vectors++;
        if (toggles1 - t0 != 90) begin
            errors++;
            $display("FAIL step3_toggles: got %0d expected 90", toggles1 - t0);
        end

        // Randomized enable with occasional mid-cycle resets.
        repeat (1500) begin
            if ($urandom_range(0, 199) == 0) begin
                stepReset(1'($urandom_range(0, 1)));
                n = $urandom_range(1, 3);
                repeat (n) step(1'($urandom_range(0, 1)));
                reset = 1'b1;
            end else begin
                step($urandom_range(0, 7) != 0);
            end
        end

        #20;
        vectors++;
        if (expQ.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: got %0d pending expected 0", expQ.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
